// File: rtl/microc_callstack.sv
// Single-cycle microcontroller datapath with a hardware return-address stack for CALL/RET.
// Optional build macro CARRY_FLAG_EN adds a carry flag driven by the add/subtract ALU ops.
module microc_callstack #(
   parameter int PW = 10,
   parameter int SD = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [15:0]   instr,
   input  logic          s_abs,
   input  logic          s_inc,
   input  logic          s_inm,
   input  logic          we3,
   input  logic          wez,
   input  logic [2:0]    op,
   input  logic          push,
   input  logic          pop,
   input  logic          wec,
   output logic [PW-1:0] pc,
   output logic [5:0]    opcode,
   output logic          z,
   output logic          c,
   output logic          stk_full,
   output logic          stk_empty,
   output logic          stk_ovf,
   output logic          stk_unf
);

   localparam int CW = $clog2(SD + 1);

   logic [PW-1:0] pc_q, pc_d;
   logic          z_q, z_d;
   logic [7:0]    regs_q [16];
   logic [7:0]    regs_d [16];
   logic [PW-1:0] stk_q [SD];
   logic [PW-1:0] stk_d [SD];
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;

   logic [7:0]    rd1, rd2, alu_y, wd;
   logic [PW-1:0] pc_inc, target, pc_mux, stk_top;
   logic          carry_n;

   assign rd1    = (instr[11:8] == 4'd0) ? 8'd0 : regs_q[instr[11:8]];
   assign rd2    = (instr[7:4] == 4'd0) ? 8'd0 : regs_q[instr[7:4]];
   assign wd     = s_inm ? instr[11:4] : alu_y;
   assign target = instr[PW-1:0];
   assign pc_inc = pc_q + PW'(1);
   assign pc_mux = s_abs ? target : (s_inc ? pc_inc : pc_q + target);

   // carry_n is the 9th sum bit: carry-out for add, NOT borrow for subtract
   always_comb begin
      alu_y   = '0;
      carry_n = 1'b0;
      unique case (op)
         3'b000: alu_y = rd1;
         3'b001: alu_y = ~rd1;
`ifdef CARRY_FLAG_EN
         3'b010: {carry_n, alu_y} = {1'b0, rd1} + {1'b0, rd2};
         3'b011: {carry_n, alu_y} = {1'b0, rd1} + {1'b0, ~rd2} + 9'd1;
`else
         3'b010: alu_y = rd1 + rd2;
         3'b011: alu_y = rd1 - rd2;
`endif
         3'b100: alu_y = rd1 & rd2;
         3'b101: alu_y = rd1 | rd2;
         3'b110: alu_y = 8'd0 - rd1;
         3'b111: alu_y = 8'd0 - rd2;
         default: alu_y = '0;
      endcase
   end

   always_comb begin
      stk_top = '0;
      for (int i = 0; i < SD; i++) begin
         if (CW'(i + 1) == count_q) stk_top = stk_q[i];
      end
   end

   always_comb begin
      regs_d = regs_q;
      if (we3 && instr[3:0] != 4'd0) regs_d[instr[3:0]] = wd;
      z_d = wez ? (alu_y == 8'd0) : z_q;
   end

   // A pop on an empty stack never blocks a simultaneous push
   always_comb begin
      pc_d    = pc_mux;
      stk_d   = stk_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      if (pop && count_q != '0) begin
         pc_d = stk_top;
         if (push) begin
            for (int i = 0; i < SD; i++) begin
               if (CW'(i + 1) == count_q) stk_d[i] = pc_inc;
            end
         end else begin
            count_d = count_q - CW'(1);
         end
      end else begin
         if (pop) begin
            unf_d = 1'b1;
            if (!push) pc_d = pc_inc;
         end
         if (push) begin
            if (count_q == CW'(SD)) begin
               ovf_d = 1'b1;
            end else begin
               for (int i = 0; i < SD; i++) begin
                  if (CW'(i) == count_q) stk_d[i] = pc_inc;
               end
               count_d = count_q + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= '0;
         z_q     <= 1'b0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         for (int i = 0; i < 16; i++) regs_q[i] <= '0;
         for (int i = 0; i < SD; i++) stk_q[i] <= '0;
      end else begin
         pc_q    <= pc_d;
         z_q     <= z_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         regs_q  <= regs_d;
         stk_q   <= stk_d;
      end
   end

`ifdef CARRY_FLAG_EN
   logic c_q, c_d;

   always_comb begin
      c_d = c_q;
      if (wec) c_d = (op == 3'b010 || op == 3'b011) ? carry_n : 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) c_q <= 1'b0;
      else       c_q <= c_d;
   end

   assign c = c_q;
`else
   logic unused_carry;
   assign unused_carry = wec ^ carry_n;
   assign c = 1'b0;
`endif

   assign pc        = pc_q;
   assign opcode    = instr[15:10];
   assign z         = z_q;
   assign stk_full  = (count_q == CW'(SD));
   assign stk_empty = (count_q == '0);
   assign stk_ovf   = ovf_q;
   assign stk_unf   = unf_q;

endmodule
